// File: rtl/i2s_recv.sv
// I2S receiver: deserialises left/right NB-bit words on CBCLK rising strobes into one DATA_BITS sample.
// Latency: sample/rcv_rdy update 1 clk after the right-LSB CBrise; rcv_rdy held until rcv_ack, overrun flags overwrite.
module i2s_recv #(
  parameter int DATA_BITS = 32,
  parameter int TPD       = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lrclk,
  input  logic                 CBrise,
  input  logic                 CBfall,
  input  logic                 inbit,
  output logic [DATA_BITS-1:0] sample,
  output logic                 rcv_rdy,
  input  logic                 rcv_ack,
  output logic                 overrun,
  output logic                 frame_err
);

  localparam int NB = DATA_BITS / 2;
  localparam int CW = (NB > 2) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {
    RX_SYNC, RX_LSKIP, RX_LEFT, RX_LWAIT, RX_RSKIP, RX_RIGHT, RX_RWAIT
  } state_t;

  state_t          state, state_nx;
  logic            lrclk_d;
  logic [CW-1:0]   cnt;
  logic [NB-1:0]   shift;
  logic [NB-1:0]   left_word;
  logic            lr_fall, lr_rise;
  logic            cnt_load, shift_en, left_done, right_done, err;
  logic            unused_ok;

  assign lr_fall   = lrclk_d & ~lrclk;
  assign lr_rise   = ~lrclk_d & lrclk;
  assign unused_ok = CBfall ^ shift[NB-1] ^ (TPD < 0);

  always_ff @(posedge clk) begin
    if (rst) state <= RX_SYNC;
    else     state <= state_nx;
  end

  // A CBrise coinciding with the accepted lrclk edge is the skipped bit,
  // so the FSM then goes straight to the capture state.
  always_comb begin
    state_nx = state;
    unique case (state)
      RX_SYNC, RX_RWAIT: begin
        if (lr_fall) state_nx = CBrise ? RX_LEFT : RX_LSKIP;
      end
      RX_LWAIT: begin
        if (lr_rise) state_nx = CBrise ? RX_RIGHT : RX_RSKIP;
      end
      RX_LSKIP, RX_LEFT, RX_RSKIP, RX_RIGHT: begin
        if (lr_fall)      state_nx = CBrise ? RX_LEFT : RX_LSKIP;
        else if (lr_rise) state_nx = RX_SYNC;
        else if (CBrise) begin
          unique case (state)
            RX_LSKIP: state_nx = RX_LEFT;
            RX_RSKIP: state_nx = RX_RIGHT;
            RX_LEFT:  if (cnt == '0) state_nx = RX_LWAIT;
            default:  if (cnt == '0) state_nx = RX_RWAIT;
          endcase
        end
      end
      default: state_nx = RX_SYNC;
    endcase
  end

  always_comb begin
    cnt_load   = 1'b0;
    shift_en   = 1'b0;
    left_done  = 1'b0;
    right_done = 1'b0;
    err        = 1'b0;
    unique case (state)
      RX_SYNC, RX_RWAIT: cnt_load = lr_fall & CBrise;
      RX_LWAIT:          cnt_load = lr_rise & CBrise;
      RX_LSKIP, RX_RSKIP: begin
        if (lr_fall | lr_rise) begin
          err      = 1'b1;
          cnt_load = lr_fall & CBrise;
        end else begin
          cnt_load = CBrise;
        end
      end
      RX_LEFT, RX_RIGHT: begin
        if (lr_fall | lr_rise) begin
          err      = 1'b1;
          cnt_load = lr_fall & CBrise;
        end else if (CBrise) begin
          shift_en   = 1'b1;
          left_done  = (state == RX_LEFT)  && (cnt == '0);
          right_done = (state == RX_RIGHT) && (cnt == '0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lrclk_d   <= 1'b0;
      cnt       <= '0;
      shift     <= '0;
      left_word <= '0;
      sample    <= '0;
      rcv_rdy   <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      lrclk_d   <= lrclk;
      frame_err <= err;
      overrun   <= right_done & rcv_rdy & ~rcv_ack;
      if (cnt_load)                  cnt <= CW'(NB - 1);
      else if (shift_en && cnt != '0) cnt <= cnt - 1'b1;
      if (shift_en)  shift     <= {shift[NB-2:0], inbit};
      if (left_done) left_word <= {shift[NB-2:0], inbit};
      // A completion beats a same-clk ack so the fresh frame is never lost.
      if (right_done) begin
        sample  <= {left_word, shift[NB-2:0], inbit};
        rcv_rdy <= 1'b1;
      end else if (rcv_ack) begin
        rcv_rdy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_recv.sv
// Directed bench for i2s_recv: 4 clk per CBCLK, 32 CBCLK per lrclk half, one-bit I2S data delay.
module tb_i2s_recv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lrclk = 1'b0;
  logic        CBrise = 1'b0;
  logic        CBfall = 1'b0;
  logic        inbit = 1'b0;
  logic        rcv_ack = 1'b0;
  logic [31:0] sample;
  logic        rcv_rdy, overrun, frame_err;

  int n_cmp = 0;
  int n_fail = 0;
  int ov_cnt = 0;
  int err_cnt = 0;
  int ov_base, err_base;

  i2s_recv #(.DATA_BITS(32), .TPD(5)) dut (
    .clk(clk), .rst(rst), .lrclk(lrclk), .CBrise(CBrise), .CBfall(CBfall),
    .inbit(inbit), .sample(sample), .rcv_rdy(rcv_rdy), .rcv_ack(rcv_ack),
    .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (overrun)   ov_cnt++;
    if (frame_err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One CBCLK period: data/lrclk change with CBfall, CBrise two clk later.
  task automatic send_slot(input logic lr, input logic b, input logic ack);
    @(negedge clk); lrclk = lr; inbit = b; CBfall = 1'b1;
    @(negedge clk); CBfall = 1'b0;
    @(negedge clk); CBrise = 1'b1; rcv_ack = ack;
    @(negedge clk); CBrise = 1'b0; rcv_ack = 1'b0;
  endtask

  // Slots 1..nbits carry w MSB first; slot 0 is the I2S delay bit.
  task automatic send_range(input logic lr, input logic [15:0] w, input int nbits,
                            input int from, input int to, input int ack_slot);
    for (int s = from; s <= to; s++) begin
      logic b;
      b = (s >= 1 && s <= nbits) ? w[16-s] : 1'b0;
      send_slot(lr, b, s == ack_slot);
    end
  endtask

  task automatic send_frame(input logic [31:0] f, input int ack_slot);
    send_range(1'b0, f[31:16], 16, 0, 31, -1);
    send_range(1'b1, f[15:0],  16, 0, 31, ack_slot);
  endtask

  task automatic ack_and_check(input string tag);
    @(negedge clk); rcv_ack = 1'b1;
    @(negedge clk); rcv_ack = 1'b0;
    check(tag, {31'd0, rcv_rdy}, 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sample", sample, 32'd0);
    check("rst_rdy", {31'd0, rcv_rdy}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;

    // Nominal frame; rcv_rdy appears exactly after the 16th right capture
    send_range(1'b1, 16'h0000, 16, 0, 31, -1);
    send_range(1'b0, 16'hA5C3, 16, 0, 31, -1);
    send_range(1'b1, 16'h3C5A, 16, 0, 15, -1);
    check("nom_rdy_before", {31'd0, rcv_rdy}, 32'd0);
    send_range(1'b1, 16'h3C5A, 16, 16, 16, -1);
    check("nom_rdy_after", {31'd0, rcv_rdy}, 32'd1);
    check("nom_sample", sample, 32'hA5C33C5A);
    check("nom_ovr", {31'd0, overrun}, 32'd0);
    send_range(1'b1, 16'h3C5A, 16, 17, 31, -1);
    ack_and_check("nom_ack_clear");

    // Start mid-frame: reset released while lrclk=1 with right data on the line
    @(negedge clk); rst = 1'b1; lrclk = 1'b1;
    @(negedge clk); rst = 1'b0;
    send_range(1'b1, 16'hBEEF, 16, 3, 31, -1);
    check("mid_rdy_partial", {31'd0, rcv_rdy}, 32'd0);
    send_range(1'b0, 16'h1111, 16, 0, 31, -1);
    check("mid_rdy_left", {31'd0, rcv_rdy}, 32'd0);
    send_range(1'b1, 16'h2222, 16, 0, 31, -1);
    check("mid_rdy", {31'd0, rcv_rdy}, 32'd1);
    check("mid_sample", sample, 32'h11112222);
    ack_and_check("mid_ack_clear");

    // Overrun: two frames without ack
    ov_base = ov_cnt;
    send_frame(32'h00010002, -1);
    send_frame(32'h00030004, -1);
    check("ovr_count", ov_cnt - ov_base, 32'd1);
    check("ovr_sample", sample, 32'h00030004);
    check("ovr_rdy", {31'd0, rcv_rdy}, 32'd1);

    // Ack in the completion clk while rcv_rdy is still high
    ov_base = ov_cnt;
    send_range(1'b0, 16'h1234, 16, 0, 31, -1);
    send_range(1'b1, 16'h5678, 16, 0, 16, 16);
    check("col_rdy", {31'd0, rcv_rdy}, 32'd1);
    check("col_sample", sample, 32'h12345678);
    check("col_ovr", {31'd0, overrun}, 32'd0);
    send_range(1'b1, 16'h5678, 16, 17, 31, -1);
    check("col_ovr_count", ov_cnt - ov_base, 32'd0);
    ack_and_check("col_ack_clear");

    // Short left half: only 10 bits before lrclk rises
    err_base = err_cnt;
    send_range(1'b0, 16'hABCD, 10, 0, 10, -1);
    send_range(1'b1, 16'h7777, 16, 0, 31, -1);
    check("short_ferr", err_cnt - err_base, 32'd1);
    check("short_rdy", {31'd0, rcv_rdy}, 32'd0);
    send_frame(32'hFFFF0000, -1);
    check("short_next_sample", sample, 32'hFFFF0000);
    check("short_next_rdy", {31'd0, rcv_rdy}, 32'd1);

    // Reset mid-right-half with a pending sample
    send_range(1'b0, 16'h5555, 16, 0, 31, -1);
    send_range(1'b1, 16'hAAAA, 16, 0, 8, -1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("mrst_sample", sample, 32'd0);
    check("mrst_rdy", {31'd0, rcv_rdy}, 32'd0);
    check("mrst_ovr", {31'd0, overrun}, 32'd0);
    check("mrst_ferr", {31'd0, frame_err}, 32'd0);
    send_range(1'b1, 16'hAAAA, 16, 9, 31, -1);
    check("mrst_rdy_after", {31'd0, rcv_rdy}, 32'd0);
    send_frame(32'hDEADBEEF, -1);
    check("mrst_sample_next", sample, 32'hDEADBEEF);
    check("mrst_rdy_next", {31'd0, rcv_rdy}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
